// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_pkg
//  Purpose  : Shared types and constants for the line-granular data memory
//             stage behind the data cache.
//  Revision : 1.0  initial release
// ============================================================================
package dmem_pkg;

   // Width of one memory line in bits
   localparam int LINE_W = 128;

   // Width of the latency down-counter; holds LAT-1 for LAT up to 15
   localparam int CNT_W = 4;

   // Controller states
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACCESS   = 2'd1,
      DONE     = 2'd2,
      WAIT_REL = 2'd3
   } state_t;

   // Latched operation kind
   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_line_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_line_ctrl_if
//  Purpose  : Cache-to-memory line bus: level requests, write-back line,
//             returned line and busy/done/err handshake.
//  Revision : 1.0  initial release
// ============================================================================
interface dmem_line_ctrl_if;

   logic [31:0]  addr_mem;
   logic         rd_mem;
   logic         wr_mem;
   logic [127:0] data_in_mem;
   logic [127:0] data_out_mem;
   logic         busy;
   logic         done;
   logic         err;

   // Cache controller side
   modport master (
      output addr_mem, rd_mem, wr_mem, data_in_mem,
      input  data_out_mem, busy, done, err
   );

   // Memory stage side
   modport slave (
      input  addr_mem, rd_mem, wr_mem, data_in_mem,
      output data_out_mem, busy, done, err
   );

endinterface : dmem_line_ctrl_if
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_array
//  Purpose  : Single-port synchronous line storage, 2**LINE_AW x LINE_W,
//             registered read data, no reset (contents undefined until
//             written).
//  Revision : 1.0  initial release
// ============================================================================
module dmem_array
   import dmem_pkg::*;
#(
   parameter int LINE_AW = 6
) (
   input  logic               clk,
   input  logic               we,
   input  logic [LINE_AW-1:0] index,
   input  logic [LINE_W-1:0]  wdata,
   output logic [LINE_W-1:0]  rdata
);

   logic [LINE_W-1:0] r_mem [2**LINE_AW];

   // Write on we, read the addressed line every cycle (read-before-write)
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[index] <= wdata;
      end
      rdata <= r_mem[index];
   end

endmodule : dmem_array
`default_nettype wire

// File: rtl/dmem_line_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_line_ctrl
//  Purpose  : Main data-memory stage. Accepts one line read or write from the
//             cache, completes it LAT+1 edges later with a done pulse, and
//             holds busy until the cache drops its level request.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_line_ctrl
   import dmem_pkg::*;
#(
   parameter int LAT     = 4,   // legal range 1..15
   parameter int LINE_AW = 6
) (
   input  logic             clk,
   input  logic             rst,   // asynchronous, active low
   dmem_line_ctrl_if.slave  bus
);

   localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(LAT - 1);

   state_t             r_state;
   op_t                r_op;
   logic [LINE_AW-1:0] r_index;
   logic [LINE_W-1:0]  r_wdata;
   logic [CNT_W-1:0]   r_cnt;
   logic [LINE_W-1:0]  r_data_out;
   logic               r_busy;
   logic               r_done;
   logic               r_err;

   logic               w_in_range;
   logic               w_one_req;
   logic               w_accept;
   logic               w_reject;
   logic               w_array_we;
   logic [LINE_W-1:0]  w_rdata;
   logic               w_unused_addr_lsb;

   // Byte offset within a line carries no information for line accesses
   assign w_unused_addr_lsb = ^bus.addr_mem[3:0];

   // Any address bit above the line index makes the request illegal
   assign w_in_range = (bus.addr_mem[31:LINE_AW+4] == '0);
   assign w_one_req  = bus.rd_mem ^ bus.wr_mem;
   assign w_accept   = w_one_req && w_in_range;
   assign w_reject   = (bus.rd_mem && bus.wr_mem) || (w_one_req && !w_in_range);

   // The array is only written in DONE, so an aborted write never lands
   assign w_array_we = (r_state == DONE) && (r_op == OP_WR);

   dmem_array #(
      .LINE_AW (LINE_AW)
   ) u_array (
      .clk   (clk),
      .we    (w_array_we),
      .index (r_index),
      .wdata (r_wdata),
      .rdata (w_rdata)
   );

   assign bus.data_out_mem = r_data_out;
   assign bus.busy         = r_busy;
   assign bus.done         = r_done;
   assign bus.err          = r_err;

   // Controller FSM with latency counter and registered handshake outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_op       <= OP_RD;
         r_index    <= '0;
         r_wdata    <= '0;
         r_cnt      <= '0;
         r_data_out <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_op    <= bus.wr_mem ? OP_WR : OP_RD;
                  r_index <= bus.addr_mem[LINE_AW+3:4];
                  r_wdata <= bus.data_in_mem;
                  r_cnt   <= C_CNT_LOAD;
                  r_busy  <= 1'b1;
                  r_state <= ACCESS;
               end else if (w_reject) begin
                  r_err <= 1'b1;
               end
            end
            ACCESS: begin
               // Request lines are ignored here; latched copies drive the array
               if (r_cnt == '0) begin
                  r_state <= DONE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            DONE: begin
               // Array read data settled while in ACCESS, so it is valid now
               r_done <= 1'b1;
               if (r_op == OP_RD) begin
                  r_data_out <= w_rdata;
               end
               r_state <= WAIT_REL;
            end
            WAIT_REL: begin
               // Stay busy until both level requests are seen low
               if (!bus.rd_mem && !bus.wr_mem) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule : dmem_line_ctrl
`default_nettype wire

// File: tb/tb_dmem_line_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_line_ctrl
//  Purpose  : Randomized self-checking bench for dmem_line_ctrl against a
//             transaction-timing reference model, plus directed scenarios.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_line_ctrl;

   localparam int LAT     = 4;
   localparam int LINE_AW = 6;
   localparam int NLINES  = 2**LINE_AW;

   localparam logic [127:0] D1   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   localparam logic [127:0] DA   = {32{4'hA}};
   localparam logic [127:0] D5   = {32{4'h5}};
   localparam logic [127:0] D11  = {32{4'h1}};
   localparam logic [127:0] D33  = {32{4'h3}};
   localparam logic [127:0] D63  = 128'hC0DE_0063_1234_5678_9ABC_DEF0_0F1E_2D3C;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   dmem_line_ctrl_if bus();

   dmem_line_ctrl #(
      .LAT     (LAT),
      .LINE_AW (LINE_AW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model (transaction timing) ----------------
   logic [127:0] mmem   [NLINES];
   bit           mvalid [NLINES];
   bit           m_inflight;
   int           m_age;
   bit           m_wr;
   int           m_idx;
   logic [127:0] m_data;
   bit           rq_one;
   bit           in_rng;
   logic         e_busy, e_done, e_err;
   logic [127:0] e_dout;
   bit           e_dout_known;

   // A request is accepted when idle; done lands LAT+1 edges later; the
   // stage is free again on the first later edge that sees both lines low.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_inflight   = 0;
         m_age        = 0;
         e_busy       = 0;
         e_done       = 0;
         e_err        = 0;
         e_dout       = '0;
         e_dout_known = 1;
      end else begin
         rq_one = bus.rd_mem ^ bus.wr_mem;
         in_rng = ((bus.addr_mem >> (LINE_AW + 4)) == 32'd0);
         e_done = 0;
         e_err  = 0;
         if (!m_inflight) begin
            if (rq_one && in_rng) begin
               m_inflight = 1;
               m_age      = 0;
               m_wr       = bus.wr_mem;
               m_idx      = int'(bus.addr_mem[LINE_AW+3:4]);
               m_data     = bus.data_in_mem;
               e_busy     = 1;
            end else if (bus.rd_mem || bus.wr_mem) begin
               e_err = 1;
            end
         end else begin
            m_age++;
            if (m_age == LAT + 1) begin
               e_done = 1;
               if (m_wr) begin
                  mmem[m_idx]   = m_data;
                  mvalid[m_idx] = 1;
               end else begin
                  e_dout       = mmem[m_idx];
                  e_dout_known = mvalid[m_idx];
               end
            end else if (m_age > LAT + 1 && !bus.rd_mem && !bus.wr_mem) begin
               m_inflight = 0;
               e_busy     = 0;
            end
         end
      end
   end

   // Every-cycle comparison of DUT outputs against the model
   always @(negedge clk) begin
      if (chk_en && rst) begin
         chk("busy", bus.busy, e_busy);
         chk("done", bus.done, e_done);
         chk("err",  bus.err,  e_err);
         if (e_dout_known) chk("data_out", bus.data_out_mem, e_dout);
      end
   end

   // ---------------- stimulus helpers ----------------
   // Called right after a negedge; returns right after a negedge with the
   // stage back in IDLE and request lines low.
   task automatic do_op(input bit is_wr, input logic [31:0] a, input logic [127:0] d,
                        input int chg_at, input int hold_extra,
                        output int lat, output logic [127:0] rv);
      lat = -1;
      rv  = '0;
      bus.addr_mem    = a;
      bus.data_in_mem = d;
      bus.rd_mem      = !is_wr;
      bus.wr_mem      = is_wr;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == chg_at) begin
            bus.addr_mem    = a ^ 32'h10;
            bus.data_in_mem = ~d;
         end
         if (bus.done) begin
            lat = k - 1;
            rv  = bus.data_out_mem;
            break;
         end
      end
      if (lat < 0) chk("op_done_timeout", bus.done, 1'b1);
      repeat (hold_extra) @(negedge clk);
      bus.rd_mem = 1'b0;
      bus.wr_mem = 1'b0;
      @(negedge clk);
   endtask

   // Hold an illegal request (conflict or out of range) for n cycles
   task automatic bad_req(input bit rd, input bit wr, input logic [31:0] a, input int n);
      bus.addr_mem = a;
      bus.rd_mem   = rd;
      bus.wr_mem   = wr;
      repeat (n) @(negedge clk);
      bus.rd_mem = 1'b0;
      bus.wr_mem = 1'b0;
      @(negedge clk);
   endtask

   // Global time limit
   initial begin
      #500000;
      $display("FAIL watchdog t=%0t simulation did not finish", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int           lat;
      int           ec;
      int           dc;
      logic [127:0] rv;
      logic [31:0]  a;
      int           r;

      bus.addr_mem    = '0;
      bus.rd_mem      = 1'b0;
      bus.wr_mem      = 1'b0;
      bus.data_in_mem = '0;
      rst             = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_err",  bus.err,  1'b0);
      chk("rst_dout", bus.data_out_mem, '0);
      @(negedge clk);
      rst    = 1'b1;
      chk_en = 1;
      @(negedge clk);

      // 1: write then read, latency LAT+1
      do_op(1'b1, 32'h0000_0030, D1, 0, 0, lat, rv);
      chk("t1_wr_lat", lat, 5);
      do_op(1'b0, 32'h0000_0030, '0, 0, 0, lat, rv);
      chk("t1_rd_lat", lat, 5);
      chk("t1_rd_data", rv, D1);

      // 2: conflicting request for 3 cycles
      ec = 0;
      dc = 0;
      bus.rd_mem = 1'b1;
      bus.wr_mem = 1'b1;
      repeat (3) begin
         @(negedge clk);
         ec += int'(bus.err);
         dc += int'(bus.done);
         chk("t2_busy", bus.busy, 1'b0);
      end
      bus.rd_mem = 1'b0;
      bus.wr_mem = 1'b0;
      @(negedge clk);
      ec += int'(bus.err);
      dc += int'(bus.done);
      chk("t2_err_cnt", ec, 3);
      chk("t2_done_cnt", dc, 0);
      chk("t2_dout", bus.data_out_mem, D1);

      // 3: out of range rejected, last line accepted
      bus.addr_mem = 32'h0000_0400;
      bus.rd_mem   = 1'b1;
      @(negedge clk);
      chk("t3_err", bus.err, 1'b1);
      chk("t3_busy", bus.busy, 1'b0);
      bus.rd_mem = 1'b0;
      @(negedge clk);
      do_op(1'b1, 32'h0000_03F0, D63, 0, 0, lat, rv);
      do_op(1'b0, 32'h0000_03F0, '0, 0, 0, lat, rv);
      chk("t3_line63", rv, D63);

      // 4: held level read gives one done, busy drops one cycle after release
      dc = 0;
      bus.addr_mem = 32'h0000_03F0;
      bus.rd_mem   = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         dc += int'(bus.done);
         chk("t4_busy_held", bus.busy, 1'b1);
      end
      bus.rd_mem = 1'b0;
      @(negedge clk);
      chk("t4_busy_rel", bus.busy, 1'b0);
      chk("t4_done_cnt", dc, 1);
      chk("t4_dout", bus.data_out_mem, D63);

      // 5: reset during a write access discards the write
      do_op(1'b1, 32'h0000_0050, DA, 0, 0, lat, rv);
      bus.addr_mem    = 32'h0000_0050;
      bus.data_in_mem = D5;
      bus.wr_mem      = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("t5_rst_busy", bus.busy, 1'b0);
      chk("t5_rst_done", bus.done, 1'b0);
      chk("t5_rst_err",  bus.err,  1'b0);
      chk("t5_rst_dout", bus.data_out_mem, '0);
      bus.wr_mem = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      do_op(1'b0, 32'h0000_0050, '0, 0, 0, lat, rv);
      chk("t5_line5", rv, DA);

      // 6: address change during ACCESS is ignored
      do_op(1'b1, 32'h0000_0020, D11, 0, 0, lat, rv);
      do_op(1'b1, 32'h0000_0030, D33, 0, 0, lat, rv);
      do_op(1'b0, 32'h0000_0020, '0, 2, 0, lat, rv);
      chk("t6_line2", rv, D11);

      // Fill every line so all later reads have a known value
      for (int i = 0; i < NLINES; i++) begin
         a = {22'd0, 6'(i), 4'($urandom)};
         do_op(1'b1, a, {$urandom, $urandom, $urandom, $urandom}, 0, 0, lat, rv);
      end

      // Randomized mix of legal and illegal traffic
      for (int n = 0; n < 120; n++) begin
         r = int'($urandom_range(0, 9));
         if (r < 7) begin
            a = {22'd0, 6'($urandom_range(0, NLINES - 1)), 4'($urandom)};
            do_op(1'($urandom_range(0, 1)), a, {$urandom, $urandom, $urandom, $urandom},
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LAT)) : 0,
                  int'($urandom_range(0, 3)), lat, rv);
         end else if (r == 7) begin
            bad_req(1'b1, 1'b1, {22'd0, 6'($urandom_range(0, NLINES - 1)), 4'd0},
                    int'($urandom_range(1, 3)));
         end else begin
            r = int'($urandom_range(0, 1));
            bad_req(r == 0, r == 1, $urandom | 32'h0000_0400, int'($urandom_range(1, 3)));
         end
      end

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_dmem_line_ctrl
`default_nettype wire

// File: doc/dmem_line_ctrl.md
Name: dmem_line_ctrl

Overview:
- Main data-memory stage directly downstream of the data-cache system.
- Accepts line-granular read and write requests from the cache controller over the existing memory bus (addr_mem, rd_mem, wr_mem).
- Returns 128-bit lines after a fixed multi-cycle latency.
- Provides a busy/done handshake so the cache FSM can sequence refills and write-backs.

Parameters:
- LAT, 4: cycles from request acceptance to completion; legal range 1..15.
- LINE_AW, 6: line-address width; the memory holds 2**LINE_AW lines of 128 bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset. rst=0 forces reset immediately, independent of clk.
- addr_mem  in  32  byte address from the cache. Bits [3:0] are ignored; bits [LINE_AW+3:4] select the line.
- rd_mem  in  1  level read request, held by the cache until done.
- wr_mem  in  1  level write request, held by the cache until done.
- data_in_mem  in  128  write-back line. Sampled at acceptance.
- data_out_mem  out  128  read line. Holds the last completed read value.
- busy  out  1  high while a request is in flight, including the WAIT_REL state.
- done  out  1  one-cycle pulse when a request completes.
- err  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset values: state IDLE, data_out_mem=0, busy=0, done=0, err=0, latency counter=0. The storage array is not reset; its contents are undefined until written.
- FSM states: IDLE, ACCESS, DONE, WAIT_REL.
- IDLE, with exactly one of rd_mem/wr_mem high and the address in range:
  - Latch the op, the line index and data_in_mem.
  - Load counter=LAT-1, set busy=1 on the next edge, go to ACCESS.
- IDLE, with rd_mem and wr_mem both high:
  - err=1 for one cycle, no access, stay in IDLE.
  - err re-pulses every cycle the condition persists.
- Out of range: addr_mem[31:LINE_AW+4] != 0 is out of range. It gets the same handling as both-high: err pulse, no access.
- ACCESS:
  - Counter decrements each cycle. At counter==0, go to DONE.
  - Request lines are ignored, so a change of addr, op or data mid-access has no effect. The latched values are used.
- DONE, held for one cycle with done=1:
  - Read: data_out_mem <= array[latched index].
  - Write: array[latched index] <= latched data; data_out_mem unchanged.
  - Then go to WAIT_REL.
- Completion latency: done asserts exactly LAT+1 edges after the accepting edge. For reads, data_out_mem is valid in the same cycle that done=1.
- WAIT_REL:
  - busy stays 1 until rd_mem=0 and wr_mem=0 are seen, then go to IDLE with busy=0.
  - This prevents a held level request from re-triggering.
  - If the release and a new request coincide, the release is honoured first. A new request needs at least one idle-low cycle on both lines.
- Reset asserted mid-operation: abort immediately to the reset values.
  - An in-flight write is discarded; the array is untouched.
- Back-to-back operations: minimum request spacing is LAT+3 cycles (accept, LAT-1 access cycles, DONE, WAIT_REL, one low cycle).
- done and err are never high in the same cycle.

Decomposition:
- Shared package dmem_pkg contains:
  - state typedef: IDLE=2'd0, ACCESS=2'd1, DONE=2'd2, WAIT_REL=2'd3;
  - LINE_W=128;
  - OP_RD/OP_WR encoding.
- One sub-module, dmem_array:
  - synchronous single-port 2**LINE_AW x 128 storage;
  - inputs: we, index, wdata;
  - output: rdata, registered;
  - no reset.
- The controller FSM, counter and error checking stay in dmem_line_ctrl.

Test Plan:
1. Write then read, LAT=4:
   - Stimulus: write addr 0x00000030 data 0x0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, hold wr_mem until done, release; then read the same addr.
   - Response: write done 5 edges after acceptance; read done 5 edges after acceptance with data_out_mem equal to the written value; busy high from acceptance through WAIT_REL.
2. Conflicting request:
   - Stimulus: rd_mem=1 and wr_mem=1 for 3 cycles in IDLE.
   - Response: err=1 for 3 cycles, busy=0, done never asserts, data_out_mem unchanged.
3. Out of range, LINE_AW=6:
   - Stimulus: read addr 0x00000400.
   - Response: err pulse, no access.
   - Stimulus: read addr 0x000003F0.
   - Response: accepted, line 63 returned.
4. Held level request:
   - Stimulus: keep rd_mem=1 for 20 cycles.
   - Response: exactly one done pulse; busy stays 1 until rd_mem drops, then 0 one cycle later.
5. Reset mid-write:
   - Stimulus: after writing 0xAAAA... to line 5, write 0x5555... to line 5 and assert rst=0 during ACCESS; after release, read line 5.
   - Response: all outputs immediately at reset values; the read returns 0xAAAA....
6. Mid-access input change:
   - Stimulus: read line 2 (holds 0x1111...), change addr_mem to line 3 during ACCESS.
   - Response: data_out_mem=0x1111....
